// File: rtl/apb_slave_responder_if.sv
// APB3 completer-side bus bundle: requester drives select/address/strobe/data, completer returns data/ready/error.
// Latency: none, wires only.
// Backpressure: carried by PREADY from completer to requester.
interface apb_slave_responder_if;
    logic        PSEL;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic        PENABLE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport slave (
        input  PSEL, PADDR, PWRITE, PENABLE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

    modport master (
        output PSEL, PADDR, PWRITE, PENABLE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_slave_responder.sv
// APB3 completer with word-addressed memory, fixed wait-state insertion and PSLVERR on bad addresses.
// Latency: setup + WAIT_CYCLES stalled access cycles + one completing access cycle.
// Backpressure: PREADY held low for WAIT_CYCLES access cycles; dropping PSEL mid-transfer aborts it.
module apb_slave_responder #(
    parameter int AWIDTH      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  PCLK,
    input  logic                  PRESETN,
    apb_slave_responder_if.slave  apb
);
    localparam int              WORDS     = 2 ** AWIDTH;
    localparam logic [AWIDTH:0] DEPTH_W   = DEPTH[AWIDTH:0];
    localparam logic [3:0]      WAIT_INIT = WAIT_CYCLES[3:0];

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    state_t              state_q,   state_d;
    logic [3:0]          cnt_q,     cnt_d;
    logic [AWIDTH-1:0]   idx_q,     idx_d;
    logic                wr_q,      wr_d;
    logic [31:0]         wdat_q,    wdat_d;
    logic                err_q,     err_d;
    logic [31:0]         prdata_q,  prdata_d;
    logic                pready_q,  pready_d;
    logic                pslverr_q, pslverr_d;
    logic [31:0]         mem_q [WORDS];

    logic                setup;
    logic                access;
    logic [AWIDTH-1:0]   addr_idx;
    logic                addr_err;
    logic [AWIDTH-1:0]   cmp_idx;
    logic                cmp_wr;
    logic                cmp_err;
    logic                mem_we;
    logic                unused_paddr_hi;

    assign setup    = apb.PSEL && !apb.PENABLE;
    assign access   = apb.PSEL &&  apb.PENABLE;
    assign addr_idx = apb.PADDR[AWIDTH+1:2];
    assign addr_err = (apb.PADDR[1:0] != 2'b00) || ({1'b0, addr_idx} >= DEPTH_W);

    // Address bits above the word index are deliberately ignored.
    assign unused_paddr_hi = ^apb.PADDR[31:AWIDTH+2];

    assign apb.PRDATA  = prdata_q;
    assign apb.PREADY  = pready_q;
    assign apb.PSLVERR = pslverr_q;

    // State register.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: setup starts a transfer, PSEL loss aborts, READY always lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (setup) begin
                    state_d = (WAIT_CYCLES == 0) ? ST_READY : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!apb.PSEL) begin
                    state_d = ST_IDLE;
                end else if (access && (cnt_q == 4'd1)) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs and transfer context: latch at setup, count waits, drive the response on entry to READY.
    always_comb begin
        idx_d     = idx_q;
        wr_d      = wr_q;
        wdat_d    = wdat_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        prdata_d  = '0;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        mem_we    = 1'b0;
        cmp_idx   = idx_q;
        cmp_wr    = wr_q;
        cmp_err   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (setup) begin
                    idx_d   = addr_idx;
                    wr_d    = apb.PWRITE;
                    wdat_d  = apb.PWDATA;
                    err_d   = addr_err;
                    cnt_d   = WAIT_INIT;
                    // Zero-wait completion must use the live setup values, not the flops.
                    cmp_idx = addr_idx;
                    cmp_wr  = apb.PWRITE;
                    cmp_err = addr_err;
                end
            end
            ST_WAIT: begin
                if (access) begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_READY: begin
                // Commit only if the requester is still in its access phase.
                mem_we = access && wr_q && !err_q;
            end
            default: begin
            end
        endcase
        if ((state_q != ST_READY) && (state_d == ST_READY)) begin
            pready_d  = 1'b1;
            pslverr_d = cmp_err;
            prdata_d  = (!cmp_wr && !cmp_err) ? mem_q[cmp_idx] : '0;
        end
    end

    // Transfer context and registered response.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            wr_q      <= 1'b0;
            wdat_q    <= '0;
            err_q     <= 1'b0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            wr_q      <= wr_d;
            wdat_q    <= wdat_d;
            err_q     <= err_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
        end
    end

    // Word memory; written on the completing edge of a good write.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            for (int i = 0; i < WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[idx_q] <= wdat_q;
        end
    end
endmodule

// File: tb/tb_apb_slave_responder.sv
// Directed bench for apb_slave_responder: three instances (0 waits/16 words, 3 waits, 4 waits)
// share one requester; sel chooses which instance sees PSEL and which response is observed.
module tb_apb_slave_responder;
    logic        pclk;
    logic        presetn;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    int          sel;
    int          n_cmp;
    int          n_bad;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdat;
        logic [31:0] rdat;
        logic        err;
        logic [4:0]  cyc;
    } vec_t;

    apb_slave_responder_if if0 ();
    apb_slave_responder_if if3 ();
    apb_slave_responder_if if4 ();

    assign if0.PSEL = psel && (sel == 0);
    assign if3.PSEL = psel && (sel == 1);
    assign if4.PSEL = psel && (sel == 2);
    assign if0.PENABLE = penable;
    assign if3.PENABLE = penable;
    assign if4.PENABLE = penable;
    assign if0.PWRITE = pwrite;
    assign if3.PWRITE = pwrite;
    assign if4.PWRITE = pwrite;
    assign if0.PADDR = paddr;
    assign if3.PADDR = paddr;
    assign if4.PADDR = paddr;
    assign if0.PWDATA = pwdata;
    assign if3.PWDATA = pwdata;
    assign if4.PWDATA = pwdata;

    always_comb begin
        prdata  = if0.PRDATA;
        pready  = if0.PREADY;
        pslverr = if0.PSLVERR;
        if (sel == 1) begin
            prdata  = if3.PRDATA;
            pready  = if3.PREADY;
            pslverr = if3.PSLVERR;
        end else if (sel == 2) begin
            prdata  = if4.PRDATA;
            pready  = if4.PREADY;
            pslverr = if4.PSLVERR;
        end
    end

    apb_slave_responder #(.AWIDTH(8), .DEPTH(16),  .WAIT_CYCLES(0)) dut0 (.PCLK(pclk), .PRESETN(presetn), .apb(if0));
    apb_slave_responder #(.AWIDTH(8), .DEPTH(256), .WAIT_CYCLES(3)) dut3 (.PCLK(pclk), .PRESETN(presetn), .apb(if3));
    apb_slave_responder #(.AWIDTH(8), .DEPTH(256), .WAIT_CYCLES(4)) dut4 (.PCLK(pclk), .PRESETN(presetn), .apb(if4));

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // One transfer: enter and leave just after a rising edge; outputs sampled on falling edges.
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdat,
                            output logic [31:0] rdat, output logic err, output int ncyc,
                            output logic setup_rdy, output logic dirty);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdat;
        rdat = '0; err = 1'b0; ncyc = 0; dirty = 1'b0;
        @(negedge pclk);
        setup_rdy = pready;
        if (prdata !== 32'h0 || pslverr !== 1'b0) dirty = 1'b1;
        @(posedge pclk); #1;
        penable = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge pclk);
            if (pready === 1'b1) begin
                ncyc = k; rdat = prdata; err = pslverr;
                break;
            end
            if (prdata !== 32'h0 || pslverr !== 1'b0) dirty = 1'b1;
            @(posedge pclk); #1;
        end
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; sel = 0;
        presetn = 1'b0;
        repeat (2) @(negedge pclk);
        n_cmp++;
        if ({if0.PRDATA, if0.PREADY, if0.PSLVERR} !== 34'h0) begin
            n_bad++; $display("FAIL reset_dut0: got %h/%b/%b want 0/0/0", if0.PRDATA, if0.PREADY, if0.PSLVERR);
        end
        n_cmp++;
        if ({if3.PRDATA, if3.PREADY, if3.PSLVERR} !== 34'h0) begin
            n_bad++; $display("FAIL reset_dut3: got %h/%b/%b want 0/0/0", if3.PRDATA, if3.PREADY, if3.PSLVERR);
        end
        n_cmp++;
        if ({if4.PRDATA, if4.PREADY, if4.PSLVERR} !== 34'h0) begin
            n_bad++; $display("FAIL reset_dut4: got %h/%b/%b want 0/0/0", if4.PRDATA, if4.PREADY, if4.PSLVERR);
        end
        @(posedge pclk); #1;
        presetn = 1'b1;
        @(posedge pclk); #1;
    endtask

    task automatic run_table(input string name, input vec_t tbl [], input int n);
        logic [31:0] rd; logic er; int nc; logic sr; logic dt;
        for (int i = 0; i < n; i++) begin
            apb_xfer(tbl[i].wr, tbl[i].addr, tbl[i].wdat, rd, er, nc, sr, dt);
            n_cmp++;
            if (rd !== tbl[i].rdat || er !== tbl[i].err || nc != int'(tbl[i].cyc) || sr !== 1'b0 || dt !== 1'b0) begin
                n_bad++;
                $display("FAIL %s[%0d]: got rdata=%h err=%b cyc=%0d setup_rdy=%b dirty=%b, want rdata=%h err=%b cyc=%0d setup_rdy=0 dirty=0",
                         name, i, rd, er, nc, sr, dt, tbl[i].rdat, tbl[i].err, tbl[i].cyc);
            end
        end
    endtask

    task automatic test_zero_wait();
        vec_t t [] = new [3];
        sel = 0;
        t[0] = '{1'b1, 32'h0000_0010, 32'hA5A5_0001, 32'h0,         1'b0, 5'd1};
        t[1] = '{1'b0, 32'h0000_0010, 32'h0,         32'hA5A5_0001, 1'b0, 5'd1};
        t[2] = '{1'b0, 32'hFFFF_FC10, 32'h0,         32'hA5A5_0001, 1'b0, 5'd1};
        run_table("zero_wait", t, 3);
    endtask

    task automatic test_wait3();
        vec_t t [] = new [6];
        sel = 1;
        t[0] = '{1'b1, 32'h0000_0004, 32'h1234_5678, 32'h0,         1'b0, 5'd4};
        t[1] = '{1'b0, 32'h0000_0004, 32'h0,         32'h1234_5678, 1'b0, 5'd4};
        t[2] = '{1'b0, 32'h0000_0040, 32'h0,         32'h0,         1'b0, 5'd4};
        t[3] = '{1'b1, 32'h0000_03FC, 32'hFACE_00FF, 32'h0,         1'b0, 5'd4};
        t[4] = '{1'b0, 32'h0000_03FC, 32'h0,         32'hFACE_00FF, 1'b0, 5'd4};
        t[5] = '{1'b1, 32'h0000_0401, 32'h0BAD_0BAD, 32'h0,         1'b1, 5'd4};
        run_table("wait3", t, 6);
    endtask

    task automatic test_errors();
        vec_t t [] = new [10];
        sel = 0;
        t[0] = '{1'b1, 32'h0000_0000, 32'h1111_2222, 32'h0,         1'b0, 5'd1};
        t[1] = '{1'b1, 32'h0000_0040, 32'hFFFF_FFFF, 32'h0,         1'b1, 5'd1};
        t[2] = '{1'b1, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0,         1'b1, 5'd1};
        t[3] = '{1'b0, 32'h0000_0000, 32'h0,         32'h1111_2222, 1'b0, 5'd1};
        t[4] = '{1'b0, 32'h0000_0040, 32'h0,         32'h0,         1'b1, 5'd1};
        t[5] = '{1'b0, 32'h0000_0011, 32'h0,         32'h0,         1'b1, 5'd1};
        t[6] = '{1'b0, 32'h0000_003C, 32'h0,         32'h0,         1'b0, 5'd1};
        t[7] = '{1'b1, 32'h0000_003C, 32'h3C3C_3C3C, 32'h0,         1'b0, 5'd1};
        t[8] = '{1'b0, 32'h0000_003C, 32'h0,         32'h3C3C_3C3C, 1'b0, 5'd1};
        t[9] = '{1'b0, 32'h0000_0400, 32'h0,         32'h1111_2222, 1'b0, 5'd1};
        run_table("errors", t, 10);
    endtask

    task automatic test_back_to_back();
        vec_t t [] = new [64];
        sel = 0;
        for (int i = 0; i < 16; i++) begin
            t[2*i]   = '{1'b1, 32'(i) * 32'd4, 32'hB000_0000 + 32'(i) * 32'h0101, 32'h0, 1'b0, 5'd1};
            t[2*i+1] = '{1'b0, 32'(i) * 32'd4, 32'h0, 32'hB000_0000 + 32'(i) * 32'h0101, 1'b0, 5'd1};
        end
        for (int i = 0; i < 16; i++) begin
            t[32+i] = '{1'b1, 32'(15 - i) * 32'd4, 32'hC000_0000 + 32'(i), 32'h0, 1'b0, 5'd1};
            t[48+i] = '{1'b0, 32'(i) * 32'd4, 32'h0, 32'hC000_0000 + 32'(15 - i), 1'b0, 5'd1};
        end
        run_table("back_to_back", t, 64);
    endtask

    task automatic test_abort();
        vec_t t [] = new [1];
        logic seen;
        sel = 1;
        t[0] = '{1'b1, 32'h0000_0008, 32'h2222_0002, 32'h0, 1'b0, 5'd4};
        run_table("abort_pre", t, 1);
        // Start a write, then drop PSEL after one wait cycle.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8; pwdata = 32'h9999_9999;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge pclk);
            if (pready !== 1'b0) seen = 1'b1;
            @(posedge pclk); #1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++; $display("FAIL abort_ready: got PREADY pulse=%b want 0", seen);
        end
        // Access phase with no setup must be ignored.
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h8; pwdata = 32'h7777_7777;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge pclk);
            if (pready !== 1'b0) seen = 1'b1;
            @(posedge pclk); #1;
        end
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++; $display("FAIL penable_only_ready: got PREADY pulse=%b want 0", seen);
        end
        t[0] = '{1'b0, 32'h0000_0008, 32'h0, 32'h2222_0002, 1'b0, 5'd4};
        run_table("abort_post", t, 1);
    endtask

    task automatic test_async_reset();
        vec_t t [] = new [2];
        int nc;
        sel = 2;
        t[0] = '{1'b1, 32'h0000_0018, 32'h6666_6666, 32'h0,         1'b0, 5'd5};
        t[1] = '{1'b0, 32'h0000_0018, 32'h0,         32'h6666_6666, 1'b0, 5'd5};
        run_table("wait4", t, 2);
        // Reset in the second wait cycle of a write to index 5.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h14; pwdata = 32'h5555_5555;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        presetn = 1'b0;
        #1;
        n_cmp++;
        if ({pready, pslverr, prdata} !== 34'h0) begin
            n_bad++; $display("FAIL rst_wait_outputs: got %b/%b/%h want 0/0/0", pready, pslverr, prdata);
        end
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        presetn = 1'b1;
        @(posedge pclk); #1;
        // Reset while PREADY is high: it must drop without waiting for a clock edge.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h18; pwdata = 32'hEEEE_EEEE;
        @(posedge pclk); #1;
        penable = 1'b1;
        nc = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge pclk);
            if (pready === 1'b1) begin
                nc = k;
                break;
            end
            @(posedge pclk); #1;
        end
        n_cmp++;
        if (nc != 5) begin
            n_bad++; $display("FAIL rst_ready_reach: got access cycles=%0d want 5", nc);
        end
        #1;
        presetn = 1'b0;
        #1;
        n_cmp++;
        if (pready !== 1'b0) begin
            n_bad++; $display("FAIL rst_ready_drop: got PREADY=%b want 0", pready);
        end
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        presetn = 1'b1;
        @(posedge pclk); #1;
        t[0] = '{1'b0, 32'h0000_0014, 32'h0, 32'h0, 1'b0, 5'd5};
        t[1] = '{1'b0, 32'h0000_0018, 32'h0, 32'h0, 1'b0, 5'd5};
        run_table("after_rst", t, 2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_zero_wait();
        test_wait3();
        test_errors();
        test_back_to_back();
        test_abort();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
